// File: rtl/conv_seq_ctrl_if.sv
// Handshake/status bundle between the conv-layer sequencer and its controller.
// With PERF_CNT_EN defined the bundle also carries the perf_cycles counter.
interface conv_seq_ctrl_if #(
  parameter int KCOL = 3,
  parameter int CH   = 32,
  parameter int NCOL = 560
) ();
  logic                      start;
  logic                      enable;
  logic                      abort;
  logic [31:0]               status;
  logic                      busy;
  logic                      done;
  logic [$clog2(KCOL+1)-1:0] kcol_idx;
  logic [$clog2(CH+1)-1:0]   ch_idx;
  logic [$clog2(NCOL+1)-1:0] col_idx;
`ifdef PERF_CNT_EN
  logic [31:0]               perf_cycles;
`endif

  modport slave (
    input  start, enable, abort,
    output status, busy, done, kcol_idx, ch_idx, col_idx
`ifdef PERF_CNT_EN
    , output perf_cycles
`endif
  );

  modport master (
    output start, enable, abort,
    input  status, busy, done, kcol_idx, ch_idx, col_idx
`ifdef PERF_CNT_EN
    , input perf_cycles
`endif
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Conv-layer control sequencer: walks kernel-column / channel / output-column loops
// and decodes the datapath status word. Optional PERF_CNT_EN adds a busy-cycle counter.
module conv_seq_ctrl #(
  parameter int KCOL      = 3,
  parameter int CH        = 32,
  parameter int EN_CYC    = 2,
  parameter int OUT_BEATS = 7,
  parameter int NCOL      = 560
) (
  input logic            clk,
  input logic            rst_n,
  conv_seq_ctrl_if.slave bus
);

  localparam int KW   = $clog2(KCOL+1);
  localparam int CW   = $clog2(CH+1);
  localparam int NW   = $clog2(NCOL+1);
  localparam int DMAX = (EN_CYC > OUT_BEATS) ? EN_CYC : OUT_BEATS;
  localparam int DW   = $clog2(DMAX+1);

  localparam logic [KW-1:0] KCOL_LAST = KW'(KCOL-1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CH-1);
  localparam logic [NW-1:0] NCOL_LAST = NW'(NCOL-1);
  localparam logic [DW-1:0] EN_LAST   = DW'(EN_CYC-1);
  localparam logic [DW-1:0] OUT_LAST  = DW'(OUT_BEATS-1);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_EN, S_ROVER, S_DISEN, S_ROVER2, S_MAC,
    S_PA, S_BA, S_CA, S_RELU, S_PAR, S_OUT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] kcol_q, kcol_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [NW-1:0] col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kcol_q  <= '0;
      ch_q    <= '0;
      col_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      kcol_q  <= kcol_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
    end
  end

  // Abort outranks everything, including a frozen (enable=0) sequencer.
  always_comb begin
    state_d = state_q;
    kcol_d  = kcol_q;
    ch_d    = ch_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      kcol_d  = '0;
      ch_d    = '0;
      col_d   = '0;
      dwell_d = '0;
    end else if (bus.enable) begin
      unique case (state_q)
        S_IDLE:   if (bus.start) state_d = S_READ;
        S_READ:   state_d = S_EN;
        S_EN: begin
          if (dwell_q == EN_LAST) begin
            dwell_d = '0;
            state_d = S_ROVER;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        S_ROVER: begin
          if (dwell_q == EN_LAST) begin
            dwell_d = '0;
            state_d = S_DISEN;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        S_DISEN:  state_d = S_ROVER2;
        S_ROVER2: state_d = S_MAC;
        S_MAC:    state_d = S_PA;
        S_PA: begin
          if (kcol_q == KCOL_LAST) begin
            kcol_d  = '0;
            state_d = S_BA;
          end else begin
            kcol_d  = kcol_q + KW'(1);
            state_d = S_READ;
          end
        end
        S_BA:     state_d = S_CA;
        S_CA: begin
          if (ch_q == CH_LAST) begin
            ch_d    = '0;
            state_d = S_RELU;
          end else begin
            ch_d    = ch_q + CW'(1);
            state_d = S_READ;
          end
        end
        S_RELU:   state_d = S_PAR;
        S_PAR:    state_d = S_OUT;
        S_OUT: begin
          if (dwell_q == OUT_LAST) begin
            dwell_d = '0;
            if (col_q == NCOL_LAST) begin
              col_d   = '0;
              state_d = S_DONE;
            end else begin
              col_d   = col_q + NW'(1);
              state_d = S_READ;
            end
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.status = 32'h0;
    unique case (state_q)
      S_READ:   bus.status = 32'h0000_0003;
      S_EN:     bus.status = 32'h0000_0033;
      S_ROVER:  bus.status = 32'h0000_0031;
      S_DISEN:  bus.status = 32'h0000_0011;
      S_ROVER2: bus.status = 32'h0000_0010;
      S_MAC:    bus.status = 32'h0000_000C;
      S_PA:     bus.status = 32'h0000_00C0;
      S_BA:     bus.status = 32'h0000_0100;
      S_CA:     bus.status = 32'h0000_0200;
      S_RELU:   bus.status = 32'h0000_0400;
      S_PAR:    bus.status = 32'h0000_0800;
      S_OUT:    bus.status = 32'h0000_1000;
      default:  bus.status = 32'h0;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.kcol_idx = kcol_q;
  assign bus.ch_idx   = ch_q;
  assign bus.col_idx  = col_q;

`ifdef PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts enabled working cycles; the value freezes through DONE/IDLE until the next start.
  always_comb begin
    perf_d = perf_q;
    if (bus.abort) begin
      perf_d = '0;
    end else if (bus.enable) begin
      if (state_q == S_IDLE) begin
        if (bus.start) perf_d = '0;
      end else if (state_q != S_DONE && perf_q != 32'hFFFF_FFFF) begin
        perf_d = perf_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule
